hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Sequences the operand-forwarding muxes and pipeline stall/flush for the 5-stage RV32I core.
- Keeps its own shadow scoreboard of destination info for the E/M/W stages, advanced in lock-step with the pipeline registers.
- Drives the 2-bit forward selects for both ALU source operands.
- Generates load-use stalls, branch flushes and multi-cycle mul/div busy stalls, using an internal counter/FSM.

Parameters:
- REG_ADDR_W, 5, register index width.
- MULDIV_LAT, 4, total E-stage occupancy of a mul/div op in cycles; must be >= 2.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- Rs1D  in  REG_ADDR_W  decode-stage source register 1.
- Rs2D  in  REG_ADDR_W  decode-stage source register 2.
- RdD  in  REG_ADDR_W  decode-stage destination register.
- RegWriteD  in  1  decode instruction writes the register file.
- ResultSrcD  in  2  decode result source; 2'b01 = load.
- MulDivD  in  1  decode instruction is a multi-cycle mul/div.
- PCSrcE  in  1  taken branch/jump resolved in E.
- ForwardAE  out  2  operand A select: 00 register file, 01 ResultW, 10 ALUResultM.
- ForwardBE  out  2  operand B select, same encoding.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID register.
- FlushD  out  1  clear IF/ID register.
- FlushE  out  1  clear ID/EX register (bubble).
- StallE  out  1  hold ID/EX register (mul/div busy).

Behaviour:
- Shadow slots E, M, W each hold {valid, rd, regwrite, isload}; slot E also holds Rs1E, Rs2E and muldiv.
- Reset (async, rst_n low): all slots invalid and zero, FSM in IDLE, counter 0. All outputs 0.
- Forwarding is combinational from the registered slots. For operand A:
  - 10 if M.regwrite && M.rd != 0 && M.rd == Rs1E.
  - else 01 if W.regwrite && W.rd != 0 && W.rd == Rs1E.
  - else 00.
  - M always has priority over W. Operand B is the same, using Rs2E. Invalid slots never forward.
- Load-use stall (lwStall) = E.isload && E.rd != 0 && (E.rd == Rs1D || E.rd == Rs2D).
  - Drives StallF = StallD = 1 and FlushE = 1 for exactly one cycle.
- Branch: PCSrcE = 1 gives FlushD = FlushE = 1.
  - If PCSrcE and lwStall coincide, flush wins: StallF/StallD are forced to 0.
- Mul/div FSM, states IDLE and BUSY:
  - IDLE -> BUSY when the instruction in slot E has muldiv set. Counter loads MULDIV_LAT-1.
  - In BUSY: StallF = StallD = StallE = 1; slot E holds; a bubble (invalid) enters M. Counter decrements each cycle.
  - BUSY -> IDLE when the counter reaches 1. The E instruction advances to M on the following edge.
  - PCSrcE cannot assert while in BUSY.
- Slot advance each posedge, in priority order:
  - StallE: E holds, M <- invalid.
  - FlushE: E <- invalid (bubble).
  - otherwise E <- D-stage info. E <- D is blocked whenever StallD is set.
  - When not StallE, W <- M and M <- E.
- Back-to-back loads, and a load followed by a branch, must each be handled independently.
- Reset asserted mid-BUSY aborts the op: FSM goes to IDLE and all stalls deassert immediately (async).

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, three 32-bit saturating counters are added: stall_cycles, flush_events, forward_events.
  - forward_events increments once per cycle in which either select is non-zero.
  - Counters are exposed on output ports of the same names and reset to 0.
- When undefined, the counters and ports do not exist and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg: enum fwd_sel_t {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10}, constant RESULT_LOAD = 2'b01, struct slot_t, and FSM state enum.
- One sub-module, muldiv_busy_ctr: the FSM plus counter, outputs busy.

Test Plan:
- Reset: hold rst_n = 0 with random inputs -> all outputs 0. Release, then add x5 = x1 + x2 -> sub x6 = x5 - x3 -> ForwardAE = 10, ForwardBE = 00 on the sub's E cycle.
- add x5; nop; or x7 = x4 | x5 -> ForwardBE = 01. With x5 written in both M and W simultaneously -> 10 (M priority).
- lw x9; add x10 = x9 + x9 -> StallF = StallD = FlushE = 1 for exactly 1 cycle, then ForwardAE = ForwardBE = 01. A write to rd = x0 -> no stall and no forwarding.
- Taken branch in E (PCSrcE = 1) while a load-use pair sits in D/E -> FlushD = FlushE = 1, StallF = StallD = 0.
- mul with MULDIV_LAT = 4 -> StallE/StallD/StallF high for 3 cycles, 3 bubbles reach M, dependent add then receives ForwardAE = 10.
- rst_n asserted during BUSY cycle 2 -> stalls drop asynchronously; after release the FSM is IDLE and the counter 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, constants and forwarding helper for the hazard controller
package hazard_pkg;

   localparam int RA_W = 5;
   localparam logic [1:0] RESULT_LOAD = 2'b01;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_t;

   typedef struct packed {
      logic            valid;
      logic [RA_W-1:0] rd;
      logic            regwrite;
      logic            isload;
   } slot_t;

   // M is checked first so the youngest producer always wins
   function automatic fwd_sel_t fwd_select(slot_t m, slot_t w, logic [RA_W-1:0] rs);
      if (m.valid && m.regwrite && (m.rd != '0) && (m.rd == rs))
         return FWD_MEM;
      else if (w.valid && w.regwrite && (w.rd != '0) && (w.rd == rs))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/muldiv_busy_ctr.sv
// rtl/muldiv_busy_ctr.sv - IDLE/BUSY sequencer holding the E stage while a mul/div completes
module muldiv_busy_ctr
   import hazard_pkg::*;
#(
   parameter int MULDIV_LAT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic busy
);

   localparam int CW = $clog2(MULDIV_LAT) + 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(MULDIV_LAT - 1);
   localparam logic [CW-1:0] LAST_VAL = CW'(1);

   md_state_t     state;
   logic [CW-1:0] cnt;

   // start fires on the edge the op enters E, so busy covers the remaining LAT-1 cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_BUSY;
                  cnt   <= LOAD_VAL;
               end
            end
            ST_BUSY: begin
               if (cnt == LAST_VAL) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign busy = (state == ST_BUSY);

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - forwarding selects and stall/flush control for the 5-stage RV32I core
// Optional event counters are built when HAZARD_STATS_EN is defined.
module hazard_controller
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = RA_W,
   parameter int MULDIV_LAT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] Rs1D,
   input  logic [REG_ADDR_W-1:0] Rs2D,
   input  logic [REG_ADDR_W-1:0] RdD,
   input  logic                  RegWriteD,
   input  logic [1:0]            ResultSrcD,
   input  logic                  MulDivD,
   input  logic                  PCSrcE,
   output logic [1:0]            ForwardAE,
   output logic [1:0]            ForwardBE,
   output logic                  StallF,
   output logic                  StallD,
   output logic                  FlushD,
   output logic                  FlushE,
   output logic                  StallE
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]           stall_cycles,
   output logic [31:0]           flush_events,
   output logic [31:0]           forward_events
`endif
);

   slot_t                 slot_e, slot_m, slot_w, slot_d;
   logic [REG_ADDR_W-1:0] rs1_e, rs2_e;
   logic                  muldiv_e;
   logic                  busy, lw_stall, branch, flush_e_int, start_md;
   logic                  unused_w;
   fwd_sel_t              fwd_a, fwd_b;

   assign fwd_a = fwd_select(slot_m, slot_w, rs1_e);
   assign fwd_b = fwd_select(slot_m, slot_w, rs2_e);

   assign lw_stall = slot_e.valid && slot_e.isload && (slot_e.rd != '0) &&
                     ((slot_e.rd == Rs1D) || (slot_e.rd == Rs2D));
   // PCSrcE is a raw input, so it is masked to keep every output low during reset
   assign branch      = PCSrcE && rst_n;
   assign flush_e_int = (lw_stall || branch) && !busy;
   assign start_md    = MulDivD && !busy && !flush_e_int;

   assign slot_d = '{valid: 1'b1, rd: RdD, regwrite: RegWriteD,
                     isload: (ResultSrcD == RESULT_LOAD)};

   muldiv_busy_ctr #(.MULDIV_LAT(MULDIV_LAT)) u_busy (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_md),
      .busy  (busy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_e   <= '0;
         slot_m   <= '0;
         slot_w   <= '0;
         rs1_e    <= '0;
         rs2_e    <= '0;
         muldiv_e <= 1'b0;
      end else begin
         slot_w <= slot_m;
         if (busy) begin
            slot_m <= '0;
         end else begin
            slot_m <= slot_e;
            // a load-use stall always flushes E, so no separate D-hold path is needed here
            if (flush_e_int) begin
               slot_e   <= '0;
               rs1_e    <= '0;
               rs2_e    <= '0;
               muldiv_e <= 1'b0;
            end else begin
               slot_e   <= slot_d;
               rs1_e    <= Rs1D;
               rs2_e    <= Rs2D;
               muldiv_e <= MulDivD;
            end
         end
      end
   end

   assign unused_w = slot_w.isload ^ muldiv_e;

   assign ForwardAE = fwd_a;
   assign ForwardBE = fwd_b;
   assign StallF    = (lw_stall && !branch) || busy;
   assign StallD    = (lw_stall && !branch) || busy;
   assign StallE    = busy;
   assign FlushD    = branch;
   assign FlushE    = flush_e_int;

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles   <= '0;
         flush_events   <= '0;
         forward_events <= '0;
      end else begin
         if ((StallF || StallD || StallE) && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
         if ((FlushD || FlushE) && (flush_events != '1))
            flush_events <= flush_events + 1'b1;
         if (((fwd_a != FWD_RF) || (fwd_b != FWD_RF)) && (forward_events != '1))
            forward_events <= forward_events + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;

   logic       clk;
   logic       rst_n;
   logic [4:0] Rs1D, Rs2D, RdD;
   logic       RegWriteD;
   logic [1:0] ResultSrcD;
   logic       MulDivD;
   logic       PCSrcE;
   logic [1:0] ForwardAE, ForwardBE;
   logic       StallF, StallD, FlushD, FlushE, StallE;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cycles, flush_events, forward_events;
`endif

   int total = 0;
   int bad   = 0;

   hazard_controller #(.REG_ADDR_W(5), .MULDIV_LAT(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Rs1D       (Rs1D),
      .Rs2D       (Rs2D),
      .RdD        (RdD),
      .RegWriteD  (RegWriteD),
      .ResultSrcD (ResultSrcD),
      .MulDivD    (MulDivD),
      .PCSrcE     (PCSrcE),
      .ForwardAE  (ForwardAE),
      .ForwardBE  (ForwardBE),
      .StallF     (StallF),
      .StallD     (StallD),
      .FlushD     (FlushD),
      .FlushE     (FlushE),
      .StallE     (StallE)
`ifdef HAZARD_STATS_EN
      ,
      .stall_cycles   (stall_cycles),
      .flush_events   (flush_events),
      .forward_events (forward_events)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic [1:0] src, input logic md);
      Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw; ResultSrcD = src; MulDivD = md;
   endtask

   task automatic drain;
      issue(0, 0, 0, 0, 2'b00, 0);
      PCSrcE = 1'b0;
      repeat (3) cyc();
   endtask

   task automatic test_reset;
      logic [8:0] outs;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         issue(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
         PCSrcE = (i == 0) ? 1'b1 : 1'($urandom);
         @(negedge clk);
         outs = {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallE};
         total++;
         if (outs !== 9'b0) begin
            bad++;
            $display("FAIL reset_outputs[%0d]: got %b want 000000000", i, outs);
         end
      end
      issue(0, 0, 0, 0, 2'b00, 0);
      PCSrcE = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_fwd_mem;
      drain();
      issue(1, 2, 5, 1, 2'b00, 0);
      cyc();
      issue(5, 3, 6, 1, 2'b00, 0);
      cyc();
      issue(0, 0, 0, 0, 2'b00, 0);
      @(negedge clk);
      total++;
      if ({ForwardAE, ForwardBE} !== 4'b1000) begin
         bad++;
         $display("FAIL fwd_mem: got A=%b B=%b want A=10 B=00", ForwardAE, ForwardBE);
      end
   endtask

   task automatic test_fwd_wb;
      drain();
      issue(1, 2, 5, 1, 2'b00, 0);
      cyc();
      issue(0, 0, 0, 0, 2'b00, 0);
      cyc();
      issue(4, 5, 7, 1, 2'b00, 0);
      cyc();
      issue(0, 0, 0, 0, 2'b00, 0);
      @(negedge clk);
      total++;
      if ({ForwardAE, ForwardBE} !== 4'b0001) begin
         bad++;
         $display("FAIL fwd_wb: got A=%b B=%b want A=00 B=01", ForwardAE, ForwardBE);
      end
      drain();
      issue(1, 2, 5, 1, 2'b00, 0);
      cyc();
      issue(1, 0, 5, 1, 2'b00, 0);
      cyc();
      issue(5, 5, 7, 1, 2'b00, 0);
      cyc();
      issue(0, 0, 0, 0, 2'b00, 0);
      @(negedge clk);
      total++;
      if ({ForwardAE, ForwardBE} !== 4'b1010) begin
         bad++;
         $display("FAIL fwd_priority: got A=%b B=%b want A=10 B=10", ForwardAE, ForwardBE);
      end
   endtask

   task automatic test_load_use;
      logic [4:0] ctl;
      drain();
      issue(1, 0, 9, 1, 2'b01, 0);
      cyc();
      issue(9, 9, 10, 1, 2'b00, 0);
      @(negedge clk);
      ctl = {StallF, StallD, FlushD, FlushE, StallE};
      total++;
      if (ctl !== 5'b11010) begin
         bad++;
         $display("FAIL lw_stall_on: got %b want 11010", ctl);
      end
      cyc();
      @(negedge clk);
      ctl = {StallF, StallD, FlushD, FlushE, StallE};
      total++;
      if (ctl !== 5'b00000) begin
         bad++;
         $display("FAIL lw_stall_one_cycle: got %b want 00000", ctl);
      end
      cyc();
      issue(0, 0, 0, 0, 2'b00, 0);
      @(negedge clk);
      total++;
      if ({ForwardAE, ForwardBE} !== 4'b0101) begin
         bad++;
         $display("FAIL lw_fwd_wb: got A=%b B=%b want A=01 B=01", ForwardAE, ForwardBE);
      end
      drain();
      issue(1, 0, 0, 1, 2'b01, 0);
      cyc();
      issue(0, 0, 11, 1, 2'b00, 0);
      @(negedge clk);
      ctl = {StallF, StallD, FlushD, FlushE, StallE};
      total++;
      if (ctl !== 5'b00000) begin
         bad++;
         $display("FAIL x0_no_stall: got %b want 00000", ctl);
      end
      cyc();
      issue(0, 0, 0, 0, 2'b00, 0);
      @(negedge clk);
      total++;
      if ({ForwardAE, ForwardBE} !== 4'b0000) begin
         bad++;
         $display("FAIL x0_no_fwd: got A=%b B=%b want A=00 B=00", ForwardAE, ForwardBE);
      end
   endtask

   task automatic test_back_to_back;
      drain();
      issue(1, 0, 9, 1, 2'b01, 0);
      cyc();
      issue(9, 0, 8, 1, 2'b01, 0);
      @(negedge clk);
      total++;
      if ({StallD, FlushE} !== 2'b11) begin
         bad++;
         $display("FAIL b2b_first_stall: got %b want 11", {StallD, FlushE});
      end
      cyc();
      @(negedge clk);
      total++;
      if ({StallD, FlushE} !== 2'b00) begin
         bad++;
         $display("FAIL b2b_first_release: got %b want 00", {StallD, FlushE});
      end
      cyc();
      issue(8, 0, 12, 1, 2'b00, 0);
      @(negedge clk);
      total++;
      if ({StallF, StallD, FlushE} !== 3'b111) begin
         bad++;
         $display("FAIL b2b_second_stall: got %b want 111", {StallF, StallD, FlushE});
      end
      cyc();
      @(negedge clk);
      total++;
      if ({StallF, StallD, FlushE} !== 3'b000) begin
         bad++;
         $display("FAIL b2b_second_release: got %b want 000", {StallF, StallD, FlushE});
      end
   endtask

   task automatic test_branch;
      logic [4:0] ctl;
      drain();
      issue(1, 0, 9, 1, 2'b01, 0);
      cyc();
      issue(9, 9, 10, 1, 2'b00, 0);
      PCSrcE = 1'b1;
      @(negedge clk);
      ctl = {StallF, StallD, FlushD, FlushE, StallE};
      total++;
      if (ctl !== 5'b00110) begin
         bad++;
         $display("FAIL branch_over_lw: got %b want 00110", ctl);
      end
      cyc();
      PCSrcE = 1'b0;
      issue(0, 0, 0, 0, 2'b00, 0);
      @(negedge clk);
      ctl = {StallF, StallD, FlushD, FlushE, StallE};
      total++;
      if (ctl !== 5'b00000) begin
         bad++;
         $display("FAIL branch_after: got %b want 00000", ctl);
      end
   endtask

   task automatic test_muldiv;
      int stalls = 0;
      int bubbles = 0;
      logic exp_stall;
      drain();
      issue(1, 2, 7, 1, 2'b00, 0);
      cyc();
      issue(1, 2, 5, 1, 2'b00, 1);
      cyc();
      issue(5, 4, 13, 1, 2'b00, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         exp_stall = (k < 3);
         if (StallE) stalls++;
         if (!dut.slot_m.valid) bubbles++;
         total++;
         if ({StallF, StallD, StallE, FlushE} !== {exp_stall, exp_stall, exp_stall, 1'b0}) begin
            bad++;
            $display("FAIL muldiv_stall[%0d]: got %b want %b", k,
                     {StallF, StallD, StallE, FlushE}, {exp_stall, exp_stall, exp_stall, 1'b0});
         end
         if (k == 4) begin
            total++;
            if ({ForwardAE, ForwardBE} !== 4'b1000) begin
               bad++;
               $display("FAIL muldiv_fwd: got A=%b B=%b want A=10 B=00", ForwardAE, ForwardBE);
            end
         end else begin
            cyc();
            issue(5, 4, 13, 1, 2'b00, 0);
         end
      end
      total++;
      if (stalls !== 3) begin
         bad++;
         $display("FAIL muldiv_stall_count: got %0d want 3", stalls);
      end
      total++;
      if (bubbles !== 3) begin
         bad++;
         $display("FAIL muldiv_bubbles: got %0d want 3", bubbles);
      end
   endtask

   task automatic test_reset_busy;
      drain();
      issue(1, 2, 5, 1, 2'b00, 1);
      cyc();
      issue(0, 0, 0, 0, 2'b00, 0);
      cyc();
      total++;
      if (StallE !== 1'b1) begin
         bad++;
         $display("FAIL rst_busy_pre: got StallE=%b want 1", StallE);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({StallF, StallD, StallE} !== 3'b000) begin
         bad++;
         $display("FAIL rst_busy_async: got %b want 000", {StallF, StallD, StallE});
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if ({dut.u_busy.state, 3'(dut.u_busy.cnt)} !== 4'b0000) begin
         bad++;
         $display("FAIL rst_busy_state: got state=%b cnt=%0d want state=0 cnt=0",
                  dut.u_busy.state, dut.u_busy.cnt);
      end
      cyc();
      @(negedge clk);
      total++;
      if ({StallF, StallD, StallE} !== 3'b000) begin
         bad++;
         $display("FAIL rst_busy_after: got %b want 000", {StallF, StallD, StallE});
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      PCSrcE = 1'b0;
      issue(0, 0, 0, 0, 2'b00, 0);
      test_reset();
      test_fwd_mem();
      test_fwd_wb();
      test_load_use();
      test_back_to_back();
      test_branch();
      test_muldiv();
      test_reset_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
